ahb_si_arbiter: RTL



---
 rtl/ahb_si_arbiter_if.sv | 36 +++
 rtl/ahb_si_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/ahb_si_arbiter_if.sv
// Bus bundle between the masters' decode/mux side and one slave-interface arbiter.
// Defining AHB_ARB_MASTLOCK_EN adds the per-master HMASTLOCK inputs.
interface ahb_si_arbiter_if #(
  parameter int CHANNEL_NUM = 2
);
  logic [CHANNEL_NUM-1:0]      req;
  logic [CHANNEL_NUM-1:0][1:0] htrans_in;
  logic [CHANNEL_NUM-1:0][2:0] hburst_in;
  logic                        hready_in;
`ifdef AHB_ARB_MASTLOCK_EN
  logic [CHANNEL_NUM-1:0]      hmastlock_in;
`endif
  logic [CHANNEL_NUM-1:0]      sel_addr;
  logic [CHANNEL_NUM-1:0]      sel_data;
  logic [CHANNEL_NUM-1:0]      hold;

`ifdef AHB_ARB_MASTLOCK_EN
  modport slave (
    input  req, htrans_in, hburst_in, hready_in, hmastlock_in,
    output sel_addr, sel_data, hold
  );
  modport master (
    output req, htrans_in, hburst_in, hready_in, hmastlock_in,
    input  sel_addr, sel_data, hold
  );
`else
  modport slave (
    input  req, htrans_in, hburst_in, hready_in,
    output sel_addr, sel_data, hold
  );
  modport master (
    output req, htrans_in, hburst_in, hready_in,
    input  sel_addr, sel_data, hold
  );
`endif
endinterface

// File: rtl/ahb_si_arbiter.sv
// Round-robin AHB slave-interface arbiter that holds the grant for a whole burst.
// Optional master lock is compiled in by defining AHB_ARB_MASTLOCK_EN.
module ahb_si_arbiter #(
  parameter int CHANNEL_NUM = 2
) (
  input  logic            hclk,
  input  logic            hreset,
  ahb_si_arbiter_if.slave bus,
  output logic [0:0]      state_dbg
);
  localparam int GW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [2:0] BURST_INCR = 3'b001;

  // Handshake: hready_in is the only flow control. A beat of the owning master
  // is accepted on a rising edge with hready_in=1 in OWNED; with hready_in=0
  // every register holds, so neither select can move during a wait state.

  logic [0:0]             state;
  logic [GW-1:0]          last_grant;
  logic [4:0]             remain;
  logic                   open_burst;
  logic [CHANNEL_NUM-1:0] sel_addr_q;
  logic [CHANNEL_NUM-1:0] sel_data_q;

  logic [1:0]             cur_trans;
  logic [2:0]             cur_burst;
  logic [4:0]             beat_remain;
  logic                   beat_open;
  logic                   release_beat;
  logic                   lock_keep;
  logic                   arb_point;
  logic                   found;
  logic [GW-1:0]          winner;
  logic [CHANNEL_NUM-1:0] winner_oh;

  // While OWNED the current owner is always last_grant.
  always_comb begin
    cur_trans = bus.htrans_in[last_grant];
    cur_burst = bus.hburst_in[last_grant];
  end

  always_comb begin
    beat_remain = remain;
    beat_open   = open_burst;
    case (cur_trans)
      TR_NONSEQ: begin
        beat_open = (cur_burst == BURST_INCR);
        case (cur_burst)
          3'b000, 3'b001: beat_remain = 5'd0;
          3'b010, 3'b011: beat_remain = 5'd3;
          3'b100, 3'b101: beat_remain = 5'd7;
          default:        beat_remain = 5'd15;
        endcase
      end
      TR_SEQ: begin
        if (remain != 5'd0) beat_remain = remain - 5'd1;
      end
      TR_BUSY: ;
      default: ;
    endcase
    release_beat = (cur_trans == TR_IDLE) ||
                   (beat_open ? !bus.req[last_grant]
                              : (cur_trans[1] && (beat_remain == 5'd0)));
  end

`ifdef AHB_ARB_MASTLOCK_EN
  assign lock_keep = bus.hmastlock_in[last_grant];
`else
  assign lock_keep = 1'b0;
`endif

  assign arb_point = (state == ST_IDLE) || (release_beat && !lock_keep);

  // Searching from last_grant+1 leaves the releasing owner for last, so it only
  // wins again when it is the sole requester.
  always_comb begin
    found  = 1'b0;
    winner = last_grant;
    for (int k = 1; k <= CHANNEL_NUM; k++) begin
      if (!found && bus.req[(int'(last_grant) + k) % CHANNEL_NUM]) begin
        found  = 1'b1;
        winner = GW'((int'(last_grant) + k) % CHANNEL_NUM);
      end
    end
    winner_oh         = '0;
    winner_oh[winner] = 1'b1;
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state      <= ST_IDLE;
      last_grant <= GW'(CHANNEL_NUM - 1);
      remain     <= 5'd0;
      open_burst <= 1'b0;
      sel_addr_q <= '0;
      sel_data_q <= '0;
    end else if (bus.hready_in) begin
      sel_data_q <= sel_addr_q;
      if (arb_point) begin
        remain     <= 5'd0;
        open_burst <= 1'b0;
        if (found) begin
          state      <= ST_OWNED;
          last_grant <= winner;
          sel_addr_q <= winner_oh;
        end else begin
          state      <= ST_IDLE;
          sel_addr_q <= '0;
        end
      end else begin
        remain     <= beat_remain;
        open_burst <= beat_open;
      end
    end
  end

  assign bus.sel_addr = sel_addr_q;
  assign bus.sel_data = sel_data_q;
  assign bus.hold     = bus.req & ~sel_addr_q;
  assign state_dbg    = state;

endmodule
